// File: rtl/hamming_secded_dec.sv
// Multi-lane Hamming(8,4) SECDED decoder. Each accepted word is decoded lane by
// lane, then the decoded nibbles and a saturating error-status word are written
// to the register bank through one registered write port.
module hamming_secded_dec #(
  parameter int DATA_WIDTH          = 32,
  parameter int LANES               = 4,
  parameter int REG_BANK_ADDR_WIDTH = 4,
  parameter int ERROR_COUNTER_WIDTH = 8,
  parameter bit WRITE_ON_CHANGE     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [REG_BANK_ADDR_WIDTH-1:0] write_address,
  input  logic [REG_BANK_ADDR_WIDTH-1:0] status_address,
  input  logic                           clr_cnt,
  output logic                           wr_en,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [REG_BANK_ADDR_WIDTH-1:0] out_address,
  output logic                           uncorr_irq
);

  localparam int AW  = REG_BANK_ADDR_WIDTH;
  localparam int EC  = ERROR_COUNTER_WIDTH;
  localparam int PCW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    WR_DATA = 2'd2,
    WR_STAT = 2'd3
  } state_t;

  // Decode one codeword: returns {uncorrectable, corrected, nibble}.
  // Flipping position s covers every single-error case: for s = 0,1,2,4 only a
  // parity bit changes, so the extracted data nibble is unaffected.
  function automatic logic [5:0] decode_lane(input logic [7:0] cw);
    logic [2:0] syn;
    logic       par;
    logic [7:0] fixed;
    syn   = {cw[4] ^ cw[5] ^ cw[6] ^ cw[7],
             cw[2] ^ cw[3] ^ cw[6] ^ cw[7],
             cw[1] ^ cw[3] ^ cw[5] ^ cw[7]};
    par   = ^cw;
    fixed = cw;
    if (par) begin
      fixed[syn] = ~cw[syn];
    end else begin
      fixed = cw;
    end
    return {(~par) & (syn != 3'd0), par, fixed[7], fixed[6], fixed[5], fixed[3]};
  endfunction

  function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [EC-1:0] sat_add(input logic [EC-1:0] a, input logic [PCW-1:0] b);
    logic [EC:0] sum;
    sum = {1'b0, a} + (EC+1)'(b);
    return sum[EC] ? {EC{1'b1}} : sum[EC-1:0];
  endfunction

  state_t                state_r, next_state_s;
  logic [DATA_WIDTH-1:0] dec_word_s, dec_r, last_wr_r, status_nxt_s;
  logic [LANES-1:0]      lane_corr_s, lane_unc_s, corr_r, unc_r;
  logic [AW-1:0]         wa_r, sa_r;
  logic [EC-1:0]         cor_cnt_r, unc_cnt_r, cor_nxt_s, unc_nxt_s;
  logic                  sticky_r, sticky_nxt_s, last_valid_r;
  logic                  accept_s, err_s, changed_s;

  assign accept_s  = (state_r == IDLE) && in_valid;
  assign err_s     = (|corr_r) | (|unc_r);
  assign changed_s = (WRITE_ON_CHANGE == 1'b0) || !last_valid_r || (dec_r != last_wr_r);

  // Parallel per-lane decode of the incoming word.
  always_comb begin
    logic [5:0] res;
    res         = 6'd0;
    dec_word_s  = '0;
    lane_corr_s = '0;
    lane_unc_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      res               = decode_lane(data_in[8*i +: 8]);
      dec_word_s[4*i +: 4] = res[3:0];
      lane_corr_s[i]    = res[4];
      lane_unc_s[i]     = res[5];
    end
  end

  // Next counter/sticky values; a clear wins over a coincident update.
  always_comb begin
    cor_nxt_s    = cor_cnt_r;
    unc_nxt_s    = unc_cnt_r;
    sticky_nxt_s = sticky_r;
    if (clr_cnt) begin
      cor_nxt_s    = '0;
      unc_nxt_s    = '0;
      sticky_nxt_s = 1'b0;
    end else if (state_r == DECODE) begin
      cor_nxt_s    = sat_add(cor_cnt_r, popcount(corr_r));
      unc_nxt_s    = sat_add(unc_cnt_r, popcount(unc_r));
      sticky_nxt_s = sticky_r | (|unc_r);
    end else begin
      cor_nxt_s    = cor_cnt_r;
      unc_nxt_s    = unc_cnt_r;
      sticky_nxt_s = sticky_r;
    end
    status_nxt_s              = '0;
    status_nxt_s[EC-1:0]      = cor_nxt_s;
    status_nxt_s[2*EC-1:EC]   = unc_nxt_s;
    status_nxt_s[2*EC]        = sticky_nxt_s;
  end

  // Write-sequencing next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = DECODE;
        else          next_state_s = IDLE;
      end
      DECODE: begin
        if (changed_s)  next_state_s = WR_DATA;
        else if (err_s) next_state_s = WR_STAT;
        else            next_state_s = IDLE;
      end
      WR_DATA: begin
        if (err_s) next_state_s = WR_STAT;
        else       next_state_s = IDLE;
      end
      WR_STAT: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_state_s;
  end

  // Capture decoded lanes and destination addresses at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_r  <= '0;
      corr_r <= '0;
      unc_r  <= '0;
      wa_r   <= '0;
      sa_r   <= '0;
    end else if (accept_s) begin
      dec_r  <= dec_word_s;
      corr_r <= lane_corr_s;
      unc_r  <= lane_unc_s;
      wa_r   <= write_address;
      sa_r   <= status_address;
    end
  end

  // Saturating error counters, sticky flag and last-written data word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cor_cnt_r    <= '0;
      unc_cnt_r    <= '0;
      sticky_r     <= 1'b0;
      last_wr_r    <= '0;
      last_valid_r <= 1'b0;
    end else begin
      cor_cnt_r <= cor_nxt_s;
      unc_cnt_r <= unc_nxt_s;
      sticky_r  <= sticky_nxt_s;
      if (state_r == WR_DATA) begin
        last_wr_r    <= dec_r;
        last_valid_r <= 1'b1;
      end
    end
  end

  // Registered outputs, loaded for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready    <= 1'b1;
      wr_en       <= 1'b0;
      data_out    <= '0;
      out_address <= '0;
      uncorr_irq  <= 1'b0;
    end else begin
      in_ready   <= (next_state_s == IDLE);
      uncorr_irq <= accept_s && (|lane_unc_s);
      case (next_state_s)
        WR_DATA: begin
          wr_en       <= 1'b1;
          out_address <= wa_r;
          data_out    <= dec_r;
        end
        WR_STAT: begin
          wr_en       <= 1'b1;
          out_address <= sa_r;
          data_out    <= status_nxt_s;
        end
        default: wr_en <= 1'b0;
      endcase
    end
  end

endmodule
